axi_lite_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank: the successor to the accelerator's fixed six-register block. It carries a configurable number of read/write and read-only registers, plus a CONTROL/STATUS pair with self-clearing start, busy tracking, sticky done and an interrupt. It sits between the PS general-purpose AXI port and the accelerator datapath. Address and write-data channels are accepted independently, and out-of-range accesses are rejected.

---
 rtl/regbank_pkg.sv | 15 +
 rtl/regbank_addr_decode.sv | 33 +++
 rtl/axi_lite_regbank.sv | 174 +++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg: register map indices, bit positions, response codes and FSM encodings for axi_lite_regbank.
package regbank_pkg;
  localparam int IDX_CONTROL = 0;
  localparam int IDX_STATUS = 1;
  localparam int IDX_RW_BASE = 2;
  localparam int BIT_START = 0;
  localparam int BIT_IRQ_EN = 1;
  localparam int BIT_BUSY = 0;
  localparam int BIT_DONE = 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {CLS_CTRL, CLS_STAT, CLS_RW, CLS_RO} reg_class_e;
  typedef enum logic {WS_IDLE, WS_RESP} wstate_e;
  typedef enum logic {RS_IDLE, RS_DATA} rstate_e;
endpackage

// File: rtl/regbank_addr_decode.sv
// regbank_addr_decode: byte address + prot to {register class, local index, error}.
// REGBANK_PROT_CHECK_EN defined: instruction-access prot (prot[2]) is flagged as an error.
module regbank_addr_decode
  import regbank_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_NUM_RW_REGS = 6,
  parameter int C_NUM_RO_REGS = 2
) (
  input  logic [C_ADDR_WIDTH-1:0] addr,
  input  logic [2:0]              prot,
  output reg_class_e              cls,
  output logic [C_ADDR_WIDTH-3:0] loc,
  output logic                    err
);
  localparam int RO_BASE = IDX_RW_BASE + C_NUM_RW_REGS;
  localparam int IDX_END = RO_BASE + C_NUM_RO_REGS;
  logic [31:0] w;
  logic prot_err;
`ifdef REGBANK_PROT_CHECK_EN
  assign prot_err = prot[2];
`else
  logic prot_unused;
  assign prot_unused = ^prot;
  assign prot_err = 1'b0;
`endif
  always_comb begin
    w = 32'(addr[C_ADDR_WIDTH-1:2]);
    cls = w == IDX_CONTROL ? CLS_CTRL : w == IDX_STATUS ? CLS_STAT : w < RO_BASE ? CLS_RW : CLS_RO;
    loc = (C_ADDR_WIDTH-2)'(cls == CLS_RO ? w - RO_BASE : w - IDX_RW_BASE);
    err = addr[1:0] != 2'b00 || w >= IDX_END || prot_err;
  end
endmodule

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite register bank with CONTROL/STATUS, RW and RO registers.
// REGBANK_PROT_CHECK_EN defined: instruction accesses (prot[2]=1) get SLVERR.
module axi_lite_regbank
  import regbank_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_NUM_RW_REGS = 6,
  parameter int C_NUM_RO_REGS = 2
) (
  input  logic                                    aclk,
  input  logic                                    areset,
  input  logic [C_ADDR_WIDTH-1:0]                 s_axi_awaddr,
  input  logic [2:0]                              s_axi_awprot,
  input  logic                                    s_axi_awvalid,
  output logic                                    s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]                 s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0]               s_axi_wstrb,
  input  logic                                    s_axi_wvalid,
  output logic                                    s_axi_wready,
  output logic [1:0]                              s_axi_bresp,
  output logic                                    s_axi_bvalid,
  input  logic                                    s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]                 s_axi_araddr,
  input  logic [2:0]                              s_axi_arprot,
  input  logic                                    s_axi_arvalid,
  output logic                                    s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]                 s_axi_rdata,
  output logic [1:0]                              s_axi_rresp,
  output logic                                    s_axi_rvalid,
  input  logic                                    s_axi_rready,
  output logic [C_NUM_RW_REGS*C_DATA_WIDTH-1:0]   rw_regs,
  input  logic [C_NUM_RO_REGS*C_DATA_WIDTH-1:0]   ro_regs,
  output logic                                    start_pulse,
  input  logic                                    done,
  output logic                                    irq
);
  localparam int SW = C_DATA_WIDTH/8;
  wstate_e wstate;
  rstate_e rstate;
  logic aw_held, w_held, aw_hs, w_hs, have_aw, have_w, wr_commit, wr_ok, wr_start, wr_clr;
  logic [C_ADDR_WIDTH-1:0] awaddr_q, waddr;
  logic [2:0] awprot_q, wprot;
  logic [C_DATA_WIDTH-1:0] wdata_q, wdata_m, rd_val;
  logic [SW-1:0] wstrb_q, wstrb_m;
  logic [C_NUM_RW_REGS-1:0][C_DATA_WIDTH-1:0] rw_q;
  logic irq_en, busy, done_q;
  reg_class_e wcls, rcls;
  logic [C_ADDR_WIDTH-3:0] wloc, rloc;
  logic werr, rerr;
  function automatic logic [C_DATA_WIDTH-1:0] merge(input logic [C_DATA_WIDTH-1:0] old_v,
      input logic [C_DATA_WIDTH-1:0] new_v, input logic [SW-1:0] strb);
    logic [C_DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < SW; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction
  // A channel handshaking this cycle is used directly so the commit lands in the next cycle.
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  assign have_aw = aw_held || aw_hs;
  assign have_w = w_held || w_hs;
  assign wr_commit = wstate == WS_IDLE && have_aw && have_w;
  assign waddr = aw_held ? awaddr_q : s_axi_awaddr;
  assign wprot = aw_held ? awprot_q : s_axi_awprot;
  assign wdata_m = w_held ? wdata_q : s_axi_wdata;
  assign wstrb_m = w_held ? wstrb_q : s_axi_wstrb;
  regbank_addr_decode #(.C_ADDR_WIDTH(C_ADDR_WIDTH), .C_NUM_RW_REGS(C_NUM_RW_REGS), .C_NUM_RO_REGS(C_NUM_RO_REGS))
    u_wdec (.addr(waddr), .prot(wprot), .cls(wcls), .loc(wloc), .err(werr));
  regbank_addr_decode #(.C_ADDR_WIDTH(C_ADDR_WIDTH), .C_NUM_RW_REGS(C_NUM_RW_REGS), .C_NUM_RO_REGS(C_NUM_RO_REGS))
    u_rdec (.addr(s_axi_araddr), .prot(s_axi_arprot), .cls(rcls), .loc(rloc), .err(rerr));
  assign wr_ok = wr_commit && !werr;
  assign wr_start = wr_ok && wcls == CLS_CTRL && wstrb_m[0] && wdata_m[BIT_START];
  assign wr_clr = wr_ok && wcls == CLS_STAT && wstrb_m[0] && wdata_m[BIT_DONE];
  assign rw_regs = rw_q;
  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate <= WS_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
      awaddr_q <= '0;
      awprot_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (wstate == WS_IDLE) begin
      if (aw_hs) begin
        awaddr_q <= s_axi_awaddr;
        awprot_q <= s_axi_awprot;
      end
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (wr_commit) begin
        wstate <= WS_RESP;
        aw_held <= 1'b0;
        w_held <= 1'b0;
        s_axi_awready <= 1'b0;
        s_axi_wready <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp <= werr ? RESP_SLVERR : RESP_OKAY;
      end else begin
        aw_held <= have_aw;
        w_held <= have_w;
        s_axi_awready <= !have_aw;
        s_axi_wready <= !have_w;
      end
    end else if (s_axi_bready) begin
      wstate <= WS_IDLE;
      s_axi_bvalid <= 1'b0;
      s_axi_awready <= 1'b1;
      s_axi_wready <= 1'b1;
    end
  end
  // done takes priority over both a new START and a DONE clear in the same cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rw_q <= '0;
      irq_en <= 1'b0;
      busy <= 1'b0;
      done_q <= 1'b0;
      start_pulse <= 1'b0;
      irq <= 1'b0;
    end else begin
      start_pulse <= wr_start && !busy && !done;
      busy <= (wr_start && !busy && !done) || (busy && !done);
      done_q <= done || (done_q && !wr_clr);
      irq <= done_q && irq_en;
      if (wr_ok && wcls == CLS_CTRL && wstrb_m[0]) irq_en <= wdata_m[BIT_IRQ_EN];
      for (int k = 0; k < C_NUM_RW_REGS; k++)
        if (wr_ok && wcls == CLS_RW && 32'(wloc) == k) rw_q[k] <= merge(rw_q[k], wdata_m, wstrb_m);
    end
  end
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < C_NUM_RW_REGS; k++)
      if (rcls == CLS_RW && 32'(rloc) == k) rd_val = rw_q[k];
    for (int k = 0; k < C_NUM_RO_REGS; k++)
      if (rcls == CLS_RO && 32'(rloc) == k) rd_val = ro_regs[k*C_DATA_WIDTH +: C_DATA_WIDTH];
    if (rcls == CLS_CTRL) rd_val[BIT_IRQ_EN] = irq_en;
    if (rcls == CLS_STAT) begin
      rd_val[BIT_BUSY] = busy;
      rd_val[BIT_DONE] = done_q;
    end
    if (rerr) rd_val = '0;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      rstate <= RS_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else if (rstate == RS_IDLE) begin
      if (s_axi_arvalid && s_axi_arready) begin
        rstate <= RS_DATA;
        s_axi_arready <= 1'b0;
        s_axi_rvalid <= 1'b1;
        s_axi_rdata <= rd_val;
        s_axi_rresp <= rerr ? RESP_SLVERR : RESP_OKAY;
      end else begin
        s_axi_arready <= 1'b1;
      end
    end else if (s_axi_rready) begin
      rstate <= RS_IDLE;
      s_axi_rvalid <= 1'b0;
      s_axi_arready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb_axi_lite_regbank: directed AXI4-Lite vectors against axi_lite_regbank with hand-computed expectations.
module tb_axi_lite_regbank;
`ifdef REGBANK_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif
  logic aclk = 1'b0, areset = 1'b1;
  logic [5:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [2:0] s_axi_awprot = '0, s_axi_arprot = '0;
  logic s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_rready = 0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [31:0] s_axi_wdata = '0, s_axi_rdata;
  logic [3:0] s_axi_wstrb = '0;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [191:0] rw_regs, snap;
  logic [63:0] ro_regs = {32'h0BAD_F00D, 32'hDEAD_BEEF};
  logic start_pulse, irq, done = 1'b0;
  int n_tests = 0, n_fail = 0, n_pulses = 0, p0;
  logic [31:0] rd;
  logic [1:0] rsp;
  logic sp;
  int lat;

  axi_lite_regbank dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .rw_regs(rw_regs), .ro_regs(ro_regs), .start_pulse(start_pulse), .done(done), .irq(irq)
  );

  always #5 aclk = ~aclk;
  always @(negedge aclk) if (start_pulse) n_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                           output logic [1:0] resp, output logic pulse);
    int t;
    logic aw_go, w_go;
    @(negedge aclk);
    s_axi_awaddr = a; s_axi_awprot = p; s_axi_awvalid = 1; s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1;
    t = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && t < 20) begin
      aw_go = s_axi_awvalid && s_axi_awready;
      w_go = s_axi_wvalid && s_axi_wready;
      @(posedge aclk); #1;
      if (aw_go) s_axi_awvalid = 0;
      if (w_go) s_axi_wvalid = 0;
      t++;
      if (s_axi_awvalid || s_axi_wvalid) @(negedge aclk);
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    t = 0;
    do begin @(negedge aclk); t++; end while (!s_axi_bvalid && t < 20);
    check("wr_bvalid_in_time", {31'd0, s_axi_bvalid}, 32'd1);
    resp = s_axi_bresp;
    pulse = start_pulse;
    s_axi_bready = 1;
    @(posedge aclk); #1;
    s_axi_bready = 0;
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [2:0] p, output logic [31:0] data,
                          output logic [1:0] resp, output int lat_o);
    int t;
    logic ar_go;
    @(negedge aclk);
    s_axi_araddr = a; s_axi_arprot = p; s_axi_arvalid = 1;
    t = 0;
    while (s_axi_arvalid && t < 20) begin
      ar_go = s_axi_arready;
      @(posedge aclk); #1;
      if (ar_go) s_axi_arvalid = 0;
      t++;
      if (s_axi_arvalid) @(negedge aclk);
    end
    s_axi_arvalid = 0;
    lat_o = 0;
    do begin @(negedge aclk); lat_o++; end while (!s_axi_rvalid && lat_o < 20);
    check("rd_rvalid_in_time", {31'd0, s_axi_rvalid}, 32'd1);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1;
    @(posedge aclk); #1;
    s_axi_rready = 0;
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    check("rst_handshake_outs", {27'd0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    check("rst_rw_regs_zero", {31'd0, |rw_regs}, 32'd0);
    check("rst_irq_start", {30'd0, irq, start_pulse}, 32'd0);
    areset = 0;
    @(negedge aclk);
    check("ready_after_rst", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);

    axi_write(6'h08, 32'hA5A5_1234, 4'hF, 3'b000, rsp, sp);
    check("wr08_bresp", {30'd0, rsp}, 32'd0);
    check("wr08_rw0", rw_regs[31:0], 32'hA5A5_1234);
    axi_read(6'h08, 3'b000, rd, rsp, lat);
    check("rd08_data", rd, 32'hA5A5_1234);
    check("rd08_rresp", {30'd0, rsp}, 32'd0);
    check("rd08_latency", lat, 32'd1);

    @(negedge aclk);
    s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'h3; s_axi_wvalid = 1;
    @(posedge aclk); #1;
    s_axi_wvalid = 0;
    repeat (2) @(negedge aclk);
    check("wfirst_no_early_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
    @(negedge aclk);
    s_axi_awaddr = 6'h0C; s_axi_awprot = 0; s_axi_awvalid = 1;
    @(posedge aclk); #1;
    s_axi_awvalid = 0;
    @(negedge aclk);
    check("wfirst_bvalid_next", {31'd0, s_axi_bvalid}, 32'd1);
    check("wfirst_rw1", rw_regs[63:32], 32'h0000_FFFF);
    s_axi_bready = 1;
    @(posedge aclk); #1;
    s_axi_bready = 0;
    axi_read(6'h0C, 3'b000, rd, rsp, lat);
    check("rd0C_data", rd, 32'h0000_FFFF);

    p0 = n_pulses;
    axi_write(6'h00, 32'h1, 4'h1, 3'b000, rsp, sp);
    check("start1_pulse_with_bvalid", {31'd0, sp}, 32'd1);
    check("start1_pulse_count", n_pulses - p0, 32'd1);
    axi_read(6'h04, 3'b000, rd, rsp, lat);
    check("status_busy", rd, 32'h1);
    axi_write(6'h00, 32'h1, 4'h1, 3'b000, rsp, sp);
    check("start2_bresp", {30'd0, rsp}, 32'd0);
    check("start2_no_pulse", n_pulses - p0, 32'd1);
    @(negedge aclk); done = 1;
    @(posedge aclk); #1; done = 0;
    axi_read(6'h04, 3'b000, rd, rsp, lat);
    check("status_done", rd, 32'h2);
    axi_read(6'h00, 3'b000, rd, rsp, lat);
    check("control_start_reads0", rd, 32'h0);

    axi_write(6'h00, 32'h2, 4'h1, 3'b000, rsp, sp);
    @(negedge aclk);
    check("irq_on", {31'd0, irq}, 32'd1);
    @(negedge aclk);
    s_axi_awaddr = 6'h04; s_axi_awvalid = 1; s_axi_wdata = 32'h2; s_axi_wstrb = 4'h1; s_axi_wvalid = 1; done = 1;
    @(posedge aclk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0; done = 0;
    @(negedge aclk);
    check("clr_vs_done_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
    s_axi_bready = 1;
    @(posedge aclk); #1;
    s_axi_bready = 0;
    axi_read(6'h04, 3'b000, rd, rsp, lat);
    check("done_set_wins", rd, 32'h2);
    check("irq_still_on", {31'd0, irq}, 32'd1);
    axi_write(6'h04, 32'h2, 4'h1, 3'b000, rsp, sp);
    @(negedge aclk);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    axi_read(6'h04, 3'b000, rd, rsp, lat);
    check("status_cleared", rd, 32'h0);

    axi_read(6'h20, 3'b000, rd, rsp, lat);
    check("ro0_data", rd, 32'hDEAD_BEEF);
    axi_read(6'h24, 3'b000, rd, rsp, lat);
    check("ro1_data", rd, 32'h0BAD_F00D);
    axi_read(6'h02, 3'b000, rd, rsp, lat);
    check("misaligned_rd_resp", {30'd0, rsp}, 32'd2);
    check("misaligned_rd_data", rd, 32'h0);
    axi_read(6'h28, 3'b000, rd, rsp, lat);
    check("unmapped_rd_resp", {30'd0, rsp}, 32'd2);
    check("unmapped_rd_data", rd, 32'h0);
    snap = rw_regs;
    axi_write(6'h3F, 32'hFFFF_FFFF, 4'hF, 3'b000, rsp, sp);
    check("wr3F_resp", {30'd0, rsp}, 32'd2);
    check("wr3F_no_change", {31'd0, rw_regs == snap}, 32'd1);
    axi_write(6'h20, 32'h1111_1111, 4'hF, 3'b000, rsp, sp);
    check("wr_ro_okay", {30'd0, rsp}, 32'd0);
    check("wr_ro_no_change", {31'd0, rw_regs == snap}, 32'd1);
    axi_write(6'h1C, 32'h12AB_3456, 4'h4, 3'b000, rsp, sp);
    check("last_rw_byte2", rw_regs[191:160], 32'h00AB_0000);

    axi_write(6'h10, 32'h1234_5678, 4'hF, 3'b100, rsp, sp);
    check("prot_wr_resp", {30'd0, rsp}, PROT_EN ? 32'd2 : 32'd0);
    check("prot_wr_reg", rw_regs[95:64], PROT_EN ? 32'h0 : 32'h1234_5678);
    axi_read(6'h08, 3'b100, rd, rsp, lat);
    check("prot_rd_resp", {30'd0, rsp}, PROT_EN ? 32'd2 : 32'd0);
    check("prot_rd_data", rd, PROT_EN ? 32'h0 : 32'hA5A5_1234);

    @(negedge aclk);
    s_axi_araddr = 6'h08; s_axi_arprot = 0; s_axi_arvalid = 1;
    @(posedge aclk); #1;
    s_axi_arvalid = 0;
    @(negedge aclk);
    check("midrst_rvalid_pending", {31'd0, s_axi_rvalid}, 32'd1);
    areset = 1;
    @(posedge aclk); #1;
    @(negedge aclk);
    check("midrst_rvalid_dropped", {31'd0, s_axi_rvalid}, 32'd0);
    check("midrst_rw_cleared", {31'd0, |rw_regs}, 32'd0);
    areset = 0;
    repeat (2) @(negedge aclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end
endmodule
